// File: rtl/clock_ce_manager.sv
// PLL lock supervisor: debounces pll_lock, sequences the domain reset and
// generates per-channel divided clock-enable strobes on the PLL clock.
module clock_ce_manager #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      refclk,
  input  logic                      reset,
  input  logic                      pll_lock,
  input  logic [CHANNELS*DIV_W-1:0] div,
  input  logic [CHANNELS*DIV_W-1:0] phase,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic                      clr_lost,
  output logic [CHANNELS-1:0]       ce,
  output logic                      rst_out_n,
  output logic                      locked,
  output logic                      lock_lost
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {S_WAIT, S_COUNT, S_RUN} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [CNT_W-1:0]         lcnt_q, lcnt_d;
  logic                     rst_out_n_q, rst_out_n_d;
  logic                     locked_q, locked_d;
  logic                     lock_lost_q, lock_lost_d;
  logic [CHANNELS-1:0]      ce_q, ce_d;
  logic [CHANNELS-1:0]      act_q, act_d;
  logic [DIV_W-1:0]         cnt_q  [CHANNELS];
  logic [DIV_W-1:0]         cnt_d  [CHANNELS];
  logic [DIV_W-1:0]         deff_q [CHANNELS];
  logic [DIV_W-1:0]         deff_d [CHANNELS];

  logic lock_s;
  assign lock_s = sync_q[SYNC_STAGES-1];

  // Lock supervisor. The WAIT->COUNT edge already counts as the first
  // synchronised-high cycle, so RUN is entered on the LOCK_CYCLES-th one.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pll_lock};
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    rst_out_n_d = rst_out_n_q;
    locked_d    = locked_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      S_WAIT: begin
        lcnt_d      = '0;
        rst_out_n_d = 1'b0;
        locked_d    = 1'b0;
        if (lock_s) begin
          state_d = S_COUNT;
          lcnt_d  = CNT_W'(1);
        end
      end
      S_COUNT: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          lcnt_d  = '0;
        end else if (lcnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d     = S_RUN;
          lcnt_d      = '0;
          rst_out_n_d = 1'b1;
          locked_d    = 1'b1;
        end else begin
          lcnt_d = lcnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d     = S_WAIT;
          rst_out_n_d = 1'b0;
          locked_d    = 1'b0;
        end
      end
      default: state_d = S_WAIT;
    endcase
    // A fresh loss wins over a simultaneous clear.
    if (state_q == S_RUN && !lock_s) lock_lost_d = 1'b1;
    else if (clr_lost)               lock_lost_d = 1'b0;
  end

  // Channel dividers: act_q marks a channel that was already counting, so a
  // 0->1 change of act_d is the load event (RUN entry or chan_en rise).
  always_comb begin
    logic [DIV_W-1:0] dv;
    logic [DIV_W-1:0] ph;
    logic [DIV_W-1:0] dn;
    dv   = '0;
    ph   = '0;
    dn   = '0;
    ce_d  = '0;
    act_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      deff_d[i] = deff_q[i];
      dv        = div[i*DIV_W +: DIV_W];
      ph        = phase[i*DIV_W +: DIV_W];
      dn        = (dv == '0) ? DIV_W'(1) : dv;
      act_d[i]  = (state_d == S_RUN) && chan_en[i];
      if (act_d[i] && !act_q[i]) begin
        deff_d[i] = dn;
        cnt_d[i]  = (ph < dn) ? ph : '0;
        ce_d[i]   = 1'b0;
      end else if (act_d[i]) begin
        if (cnt_q[i] == deff_q[i] - DIV_W'(1)) begin
          cnt_d[i]  = '0;
          ce_d[i]   = 1'b1;
          deff_d[i] = dn;
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
          ce_d[i]  = 1'b0;
        end
      end else begin
        cnt_d[i] = '0;
        ce_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      state_q     <= S_WAIT;
      lcnt_q      <= '0;
      rst_out_n_q <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      ce_q        <= '0;
      act_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        deff_q[i] <= '0;
      end
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      rst_out_n_q <= rst_out_n_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      ce_q        <= ce_d;
      act_q       <= act_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        deff_q[i] <= deff_d[i];
      end
    end
  end

  assign ce        = ce_q;
  assign rst_out_n = rst_out_n_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_clock_ce_manager.sv
// Directed bench for clock_ce_manager: expected output vectors
// {rst_out_n, locked, lock_lost, ce[1], ce[0]} are queued per cycle and checked.
module tb_clock_ce_manager;

  localparam int CHANNELS = 2;
  localparam int DIV_W    = 8;
  localparam int W        = 5;

  logic                      refclk;
  logic                      reset;
  logic                      pll_lock;
  logic [CHANNELS*DIV_W-1:0] div;
  logic [CHANNELS*DIV_W-1:0] phase;
  logic [CHANNELS-1:0]       chan_en;
  logic                      clr_lost;
  logic [CHANNELS-1:0]       ce;
  logic                      rst_out_n;
  logic                      locked;
  logic                      lock_lost;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  clock_ce_manager #(
    .CHANNELS(CHANNELS), .DIV_W(DIV_W), .LOCK_CYCLES(16), .SYNC_STAGES(2)
  ) dut (
    .refclk(refclk), .reset(reset), .pll_lock(pll_lock), .div(div),
    .phase(phase), .chan_en(chan_en), .clr_lost(clr_lost), .ce(ce),
    .rst_out_n(rst_out_n), .locked(locked), .lock_lost(lock_lost)
  );

  // clock / reset
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  function automatic logic [W-1:0] mk(input bit r, input bit l, input bit lost,
                                      input bit c1, input bit c0);
    return {r, l, lost, c1, c0};
  endfunction

  function automatic logic [W-1:0] observed();
    return {rst_out_n, locked, lock_lost, ce[1], ce[0]};
  endfunction

  // Queue the expectation for the coming edge, then compare after it.
  task automatic step(input logic [W-1:0] e, input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    exp_q.push_back(e);
    @(negedge refclk);
    obs   = observed();
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp_v);
    end
  endtask

  initial begin
    logic [W-1:0] obs;
    reset    = 1'b0;
    pll_lock = 1'b0;
    clr_lost = 1'b0;
    div      = {8'd0, 8'd4};
    phase    = '0;
    chan_en  = 2'b11;

    step('0, "reset_state");
    step('0, "reset_state");
    reset = 1'b1;
    step('0, "wait_no_lock");
    step('0, "wait_no_lock");

    // Lock latency 18 edges, ce0 every 4, ce1 constant, div0 4->6 mid-count
    pll_lock = 1'b1;
    for (int k = 1; k <= 47; k++) begin
      bit c0;
      if (k <= 34) c0 = (k > 18) && ((k - 18) % 4 == 0);
      else         c0 = ((k - 34) % 6 == 0);
      step(mk(k >= 18, k >= 18, 1'b0, k >= 19, c0), "lock_run");
      if (k == 31) div[7:0] = 8'd6;
    end

    // Loss of lock while in RUN
    pll_lock = 1'b0;
    step(mk(1, 1, 0, 1, 0), "loss_sync");
    step(mk(1, 1, 0, 1, 0), "loss_sync");
    step(mk(0, 0, 1, 0, 0), "loss_edge");
    step(mk(0, 0, 1, 0, 0), "lost_sticky");
    step(mk(0, 0, 1, 0, 0), "lost_sticky");
    clr_lost = 1'b1;
    step(mk(0, 0, 0, 0, 0), "clr_lost");
    clr_lost = 1'b0;
    step(mk(0, 0, 0, 0, 0), "clr_hold");

    // Lock glitch restarts the debounce; phase0=2 gives an early first strobe
    div[7:0]   = 8'd4;
    phase[7:0] = 8'd2;
    pll_lock   = 1'b1;
    repeat (10) step('0, "glitch_pre");
    pll_lock = 1'b0;
    step('0, "glitch_low");
    pll_lock = 1'b1;
    for (int j = 1; j <= 26; j++) begin
      bit c0;
      c0 = (j > 18) && ((j - 20) % 4 == 0);
      step(mk(j >= 18, j >= 18, 1'b0, j >= 19, c0), "glitch_relock");
    end

    // Loss coinciding with clr_lost keeps lock_lost set
    pll_lock = 1'b0;
    step(mk(1, 1, 0, 1, 0), "loss2_sync");
    step(mk(1, 1, 0, 1, 1), "loss2_sync");
    clr_lost = 1'b1;
    step(mk(0, 0, 1, 0, 0), "clr_vs_set");
    clr_lost = 1'b0;
    step(mk(0, 0, 1, 0, 0), "lost_kept");
    clr_lost = 1'b1;
    step(mk(0, 0, 0, 0, 0), "clr_later");
    clr_lost = 1'b0;

    // phase0=9 >= div0=4 acts as 0; chan_en0 drop and re-enable in RUN
    phase[7:0] = 8'd9;
    pll_lock   = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      bit c0;
      if (j <= 27)      c0 = (j > 18) && ((j - 18) % 4 == 0);
      else if (j <= 32) c0 = 1'b0;
      else              c0 = ((j - 32) % 4 == 0);
      step(mk(j >= 18, j >= 18, 1'b0, j >= 19, c0), "phase_wrap_en");
      if (j == 27) chan_en[0] = 1'b0;
      if (j == 31) chan_en[0] = 1'b1;
    end

    // Asynchronous reset mid-operation, then restart from WAIT
    #2 reset = 1'b0;
    #1 obs = observed();
    checks++;
    assert (obs === '0) else begin
      errors++;
      $error("FAIL async_reset observed=%b expected=%b", obs, 5'b0);
    end
    step('0, "reset_hold");
    reset = 1'b1;
    for (int j = 1; j <= 18; j++)
      step(mk(j >= 18, j >= 18, 1'b0, 1'b0, 1'b0), "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
